muldiv_sequencer: RTL

- Iterative RV32M-subset unit (MUL, DIV, DIVU, REM, REMU) for the execute stage.
- Owns one existing ALU instance and sequences it one iteration per cycle: ALU_ADD for shift-add multiply, ALU_SUB for restoring divide.
- Sits beside the main ALU and stalls the pipeline through a valid/ready handshake on both sides.

---
 rtl/muldiv_sequencer_pkg.sv | 51 +++++
 rtl/muldiv_sequencer_alu.sv | 21 ++
 rtl/muldiv_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and its ALU.
// Op codes, FSM states, ALU op codes and the divide/unsupported-op fast-path helper.
package muldiv_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] MD_MUL  = 3'b000;
    localparam logic [2:0] MD_DIV  = 3'b100;
    localparam logic [2:0] MD_DIVU = 3'b101;
    localparam logic [2:0] MD_REM  = 3'b110;
    localparam logic [2:0] MD_REMU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1
    } alu_op_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Returns {hit, value}; hit means the result is known without iterating.
    function automatic logic [XLEN:0] fast_path(input logic [2:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic b_zero;
        logic ovf;
        b_zero = (b == {XLEN{1'b0}});
        ovf    = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
        case (op)
            MD_MUL:  return {1'b0, {XLEN{1'b0}}};
            MD_DIV:  return b_zero ? {1'b1, {XLEN{1'b1}}} :
                            (ovf ? {1'b1, 1'b1, {(XLEN-1){1'b0}}} : {1'b0, {XLEN{1'b0}}});
            MD_DIVU: return b_zero ? {1'b1, {XLEN{1'b1}}} : {1'b0, {XLEN{1'b0}}};
            MD_REM:  return b_zero ? {1'b1, a} :
                            (ovf ? {1'b1, {XLEN{1'b0}}} : {1'b0, {XLEN{1'b0}}});
            MD_REMU: return b_zero ? {1'b1, a} : {1'b0, {XLEN{1'b0}}};
            default: return {1'b1, {XLEN{1'b0}}};
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Existing shared ALU, reused here as the single adder/subtractor of the sequencer.
module alu_module
    import muldiv_sequencer_pkg::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    // Add/subtract select
    always_comb begin
        result = {XLEN{1'b0}};
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/DIV/DIVU/REM/REMU unit: one ALU iteration per cycle, 32 RUN cycles.
// Optional macro MULDIV_EARLY_OUT_EN ends MUL early once the remaining multiplier is zero.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // mcand_r holds multiplicand or divisor; mplier_r holds multiplier or dividend/quotient.
    state_t            state_r, state_nx;
    logic [CNT_W-1:0]  cnt_r, cnt_nx;
    logic [2:0]        op_r, op_nx;
    logic [XLEN-1:0]   acc_r, acc_nx;
    logic [XLEN-1:0]   mcand_r, mcand_nx;
    logic [XLEN-1:0]   mplier_r, mplier_nx;
    logic              neg_q_r, neg_q_nx;
    logic              neg_r_r, neg_r_nx;
    logic [XLEN-1:0]   result_r, result_nx;
    logic              in_ready_r, out_valid_r;

    logic [XLEN:0]     rem33_s;
    logic              quo_bit_s;
    logic [XLEN:0]     fast_s;
    logic              signed_op_s;
    logic [XLEN-1:0]   fix_val_s;
    logic              fix_neg_s;
    alu_op_t           alu_op_s;
    logic [XLEN-1:0]   alu_a_s, alu_b_s, alu_res_s;

    assign rem33_s     = {acc_r, mplier_r[XLEN-1]};
    assign quo_bit_s   = rem33_s[XLEN] || (rem33_s[XLEN-1:0] >= mcand_r);
    assign fast_s      = fast_path(in_op, in_a, in_b);
    assign signed_op_s = (op_r == MD_DIV) || (op_r == MD_REM);
    assign fix_val_s   = ((op_r == MD_DIV) || (op_r == MD_DIVU)) ? mplier_r : acc_r;
    assign fix_neg_s   = (op_r == MD_DIV) ? neg_q_r : ((op_r == MD_REM) ? neg_r_r : 1'b0);

    alu_module u_alu (
        .op     (alu_op_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .result (alu_res_s)
    );

    // ALU operand steering: add for MUL RUN, subtract for DIV RUN and FIX negation
    always_comb begin
        alu_op_s = ALU_ADD;
        alu_a_s  = acc_r;
        alu_b_s  = {XLEN{1'b0}};
        case (state_r)
            ST_RUN: begin
                if (op_r == MD_MUL) begin
                    alu_op_s = ALU_ADD;
                    alu_a_s  = acc_r;
                    alu_b_s  = mcand_r;
                end else begin
                    alu_op_s = ALU_SUB;
                    alu_a_s  = rem33_s[XLEN-1:0];
                    alu_b_s  = mcand_r;
                end
            end
            ST_FIX: begin
                alu_op_s = ALU_SUB;
                alu_a_s  = {XLEN{1'b0}};
                alu_b_s  = fix_val_s;
            end
            default: begin
                alu_op_s = ALU_ADD;
                alu_b_s  = {XLEN{1'b0}};
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        op_nx     = op_r;
        acc_nx    = acc_r;
        mcand_nx  = mcand_r;
        mplier_nx = mplier_r;
        neg_q_nx  = neg_q_r;
        neg_r_nx  = neg_r_r;
        result_nx = result_r;
        if (flush) begin
            state_nx  = ST_IDLE;
            cnt_nx    = {CNT_W{1'b0}};
            op_nx     = 3'b000;
            acc_nx    = {XLEN{1'b0}};
            mcand_nx  = {XLEN{1'b0}};
            mplier_nx = {XLEN{1'b0}};
            neg_q_nx  = 1'b0;
            neg_r_nx  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_nx     = in_op;
                        mcand_nx  = in_a;
                        mplier_nx = in_b;
                        if (fast_s[XLEN]) begin
                            result_nx = fast_s[XLEN-1:0];
                            state_nx  = ST_DONE;
                        end else begin
                            state_nx  = ST_PREP;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_PREP: begin
                    acc_nx = {XLEN{1'b0}};
                    cnt_nx = {CNT_W{1'b0}};
                    if (op_r == MD_MUL) begin
                        neg_q_nx = 1'b0;
                        neg_r_nx = 1'b0;
                    end else begin
                        // Divide: dividend moves to mplier_r, divisor to mcand_r.
                        mplier_nx = signed_op_s ? abs_val(mcand_r) : mcand_r;
                        mcand_nx  = signed_op_s ? abs_val(mplier_r) : mplier_r;
                        neg_q_nx  = signed_op_s & (mcand_r[XLEN-1] ^ mplier_r[XLEN-1]);
                        neg_r_nx  = signed_op_s & mcand_r[XLEN-1];
                    end
                    state_nx = ST_RUN;
                end
                ST_RUN: begin
                    cnt_nx = cnt_r + CNT_W'(1);
                    if (op_r == MD_MUL) begin
                        acc_nx    = mplier_r[0] ? alu_res_s : acc_r;
                        mcand_nx  = mcand_r << 1;
                        mplier_nx = mplier_r >> 1;
                    end else begin
                        acc_nx    = quo_bit_s ? alu_res_s : rem33_s[XLEN-1:0];
                        mplier_nx = {mplier_r[XLEN-2:0], quo_bit_s};
                    end
                    if (cnt_r == CNT_MAX) begin
                        state_nx = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if ((op_r == MD_MUL) && (mplier_r[XLEN-1:1] == {(XLEN-1){1'b0}})) begin
                        state_nx = ST_FIX;
`endif
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                ST_FIX: begin
                    result_nx = fix_neg_s ? alu_res_s : fix_val_s;
                    state_nx  = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= 3'b000;
            acc_r       <= {XLEN{1'b0}};
            mcand_r     <= {XLEN{1'b0}};
            mplier_r    <= {XLEN{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            op_r        <= op_nx;
            acc_r       <= acc_nx;
            mcand_r     <= mcand_nx;
            mplier_r    <= mplier_nx;
            neg_q_r     <= neg_q_nx;
            neg_r_r     <= neg_r_nx;
            result_r    <= result_nx;
            in_ready_r  <= (state_nx == ST_IDLE);
            out_valid_r <= (state_nx == ST_DONE);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = result_r;

endmodule
